// File: rtl/veri_io_pkg.sv
// Shared word offsets and status-bit positions for the VERI_RISC I/O responder.
package veri_io_pkg;

    localparam int unsigned OFS_DATA   = 0;
    localparam int unsigned OFS_STATUS = 1;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_OVF      = 3;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only if a pop happens in the same cycle.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    // Head is masked while empty so the stream data reads 0 when idle.
    assign rdata    = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/veri_io_port.sv
// Memory-mapped I/O responder: DATA word feeds a TX FIFO / reads the RX byte, STATUS word flags.
// Optional RX path is built only when VERI_IO_RX_EN is defined.
module veri_io_port
    import veri_io_pkg::*;
#(
    parameter int unsigned          AWIDTH    = 5,
    parameter int unsigned          DWIDTH    = 8,
    parameter logic [AWIDTH-1:0]    BASE_ADDR = 5'h1E,
    parameter int unsigned          TX_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_oe,
    output logic              sel_io,
    output logic [DWIDTH-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DWIDTH-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam logic [AWIDTH-1:0] DATA_ADDR   = BASE_ADDR + AWIDTH'(OFS_DATA);
    localparam logic [AWIDTH-1:0] STATUS_ADDR = BASE_ADDR + AWIDTH'(OFS_STATUS);

    logic              is_data, is_status;
    logic              wr_q, wr_edge;
    logic              push, pop, tx_full, tx_empty, fifo_ovf;
    logic              ovf_q;
    logic              rx_full;
    logic [DWIDTH-1:0] rx_hold;
    logic [DWIDTH-1:0] status;

    assign is_data   = (addr == DATA_ADDR);
    assign is_status = (addr == STATUS_ADDR);
    assign sel_io    = is_data | is_status;
    assign data_oe   = rd & sel_io & ~rst;

    assign wr_edge = wr & ~wr_q;
    assign push    = wr_edge & is_data;
    assign pop     = tx_valid & tx_ready;

    io_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wdata    (data_in),
        .rdata    (tx_data),
        .full     (tx_full),
        .empty    (tx_empty),
        .overflow (fifo_ovf)
    );

    assign tx_valid = ~tx_empty;

    // wr_q follows wr even in reset so a strobe held across reset release is not an edge.
    always_ff @(posedge clk) begin
        wr_q <= wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= fifo_ovf | (ovf_q & ~(wr_edge & is_status));
        end
    end

`ifdef VERI_IO_RX_EN
    logic              rx_full_q, rd_q, rx_release;
    logic [DWIDTH-1:0] rx_hold_q;

    // rd_q remembers a DATA read so its falling edge releases the held byte.
    assign rx_release = rd_q & ~rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_full_q <= 1'b0;
            rx_hold_q <= '0;
            rd_q      <= 1'b0;
        end else begin
            rd_q <= rd & is_data;
            if (rx_valid & ~rx_full_q) begin
                rx_hold_q <= rx_data;
                rx_full_q <= 1'b1;
            end else if (rx_release) begin
                rx_full_q <= 1'b0;
            end
        end
    end

    assign rx_full  = rx_full_q;
    assign rx_hold  = rx_hold_q;
    assign rx_ready = ~rx_full_q;
`else
    logic unused_rx;

    assign unused_rx = ^{rx_data, rx_valid};
    assign rx_full   = 1'b0;
    assign rx_hold   = '0;
    assign rx_ready  = 1'b0;
`endif

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVF]      = ovf_q;
    end

    always_comb begin
        data_out = '0;
        if (data_oe) begin
            if (is_status) begin
                data_out = status;
            end else if (rx_full) begin
                data_out = rx_hold;
            end
        end
    end

endmodule
